// File: rtl/sound_event_sequencer_if.sv
// Request/tone bus between the game logic and the sound event sequencer.
// The master raises requests and mute. The slave returns the note divisors and status.
interface sound_event_sequencer_if;
  logic        ev_jump;
  logic        ev_score;
  logic        ev_over;
  logic        mute;
  logic [21:0] note_div_left;
  logic [21:0] note_div_right;
  logic [1:0]  active_src;
  logic        busy;
  logic        done;

  modport master (
    output ev_jump, ev_score, ev_over, mute,
    input  note_div_left, note_div_right, active_src, busy, done
  );

  modport slave (
    input  ev_jump, ev_score, ev_over, mute,
    output note_div_left, note_div_right, active_src, busy, done
  );
endinterface

// File: rtl/sound_event_sequencer.sv
// Arbitrates jump/score/game-over sound requests and plays each source's note pattern.
// The design drives note_gen divisors, paces beats with a prescaler, and separates sequences with an optional gap.
module sound_event_sequencer #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned GAP_BEATS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sound_event_sequencer_if.slave bus
);
  localparam logic [21:0] SIL    = 22'd1;
  localparam logic [21:0] DIV_C3 = 22'(CLK_HZ / (2 * 262));
  localparam logic [21:0] DIV_C4 = 22'(CLK_HZ / (2 * 524));
  localparam logic [21:0] DIV_E4 = 22'(CLK_HZ / (2 * 660));
  localparam logic [21:0] DIV_G4 = 22'(CLK_HZ / (2 * 784));

  localparam int unsigned   PW       = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(BEAT_CYCLES - 1);
  localparam int unsigned   GW       = (GAP_BEATS > 2) ? $clog2(GAP_BEATS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BEATS - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t        state, state_n;
  logic [1:0]    src, src_n;
  logic [1:0]    step, step_n;
  logic [1:0]    beat, beat_n;
  logic [PW-1:0] pre, pre_n;
  logic [GW-1:0] gap, gap_n;
  logic [2:0]    pend, pend_n;
  logic          done_q, done_n;
  logic          busy_q;
  logic [21:0]   div_l, div_l_n;
  logic [21:0]   div_r, div_r_n;

  logic [2:0] ev, req;
  logic [1:0] hi_ev, hi_req, start_src;
  logic       tick, start;

  function automatic logic [1:0] top_src(input logic [2:0] v);
    if (v[2])      return 2'd3;
    else if (v[1]) return 2'd2;
    else if (v[0]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [2:0] src_bit(input logic [1:0] s);
    case (s)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] last_step(input logic [1:0] s);
    case (s)
      2'd2:    return 2'd1;
      2'd3:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Index of the final beat within a step. Only score's first note is a single beat.
  function automatic logic [1:0] last_beat(input logic [1:0] s, input logic [1:0] st);
    if (s == 2'd2) return (st == 2'd0) ? 2'd0 : 2'd2;
    return 2'd1;
  endfunction

  function automatic logic [21:0] step_div(input logic [1:0] s, input logic [1:0] st);
    case (s)
      2'd2: return (st == 2'd0) ? DIV_C4 : DIV_G4;
      2'd3: begin
        case (st)
          2'd0:    return DIV_G4;
          2'd1:    return DIV_E4;
          2'd2:    return DIV_C4;
          default: return DIV_C3;
        endcase
      end
      default: return DIV_C4;
    endcase
  endfunction

  assign ev     = {bus.ev_over, bus.ev_score, bus.ev_jump};
  assign req    = pend | ev;
  assign hi_ev  = top_src(ev);
  assign hi_req = top_src(req);
  assign tick   = (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      src    <= '0;
      step   <= '0;
      beat   <= '0;
      pre    <= '0;
      gap    <= '0;
      pend   <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      div_l  <= SIL;
      div_r  <= SIL;
    end else begin
      state  <= state_n;
      src    <= src_n;
      step   <= step_n;
      beat   <= beat_n;
      pre    <= pre_n;
      gap    <= gap_n;
      pend   <= pend_n;
      done_q <= done_n;
      busy_q <= (state_n != IDLE);
      div_l  <= div_l_n;
      div_r  <= div_r_n;
    end
  end

  always_comb begin
    state_n   = state;
    src_n     = src;
    step_n    = step;
    beat_n    = beat;
    gap_n     = gap;
    pend_n    = req;
    done_n    = 1'b0;
    start     = 1'b0;
    start_src = 2'd0;
    pre_n     = (state == IDLE || tick) ? '0 : pre + PW'(1);

    unique case (state)
      IDLE: begin
        if (ev != 3'b000) begin
          start     = 1'b1;
          start_src = hi_req;
        end
      end
      GAP: begin
        if (ev != 3'b000 || (tick && gap == GAP_LAST)) begin
          start     = 1'b1;
          start_src = hi_req;
        end else if (tick) begin
          gap_n = gap + GW'(1);
        end
      end
      PLAY: begin
        // Equal priority is a retrigger and higher is a preemption. Both restart cleanly without done.
        if (hi_ev != 2'd0 && hi_ev >= src) begin
          start     = 1'b1;
          start_src = hi_ev;
        end else if (tick) begin
          if (beat != last_beat(src, step)) begin
            beat_n = beat + 2'd1;
          end else if (step != last_step(src)) begin
            step_n = step + 2'd1;
            beat_n = '0;
          end else begin
            done_n = 1'b1;
            if (req == 3'b000) begin
              state_n = IDLE;
              src_n   = '0;
            end else if (GAP_BEATS == 0) begin
              start     = 1'b1;
              start_src = hi_req;
            end else begin
              state_n = GAP;
              src_n   = '0;
              gap_n   = '0;
              pre_n   = '0;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (start) begin
      state_n = PLAY;
      src_n   = start_src;
      step_n  = '0;
      beat_n  = '0;
      pre_n   = '0;
      pend_n  = req & ~src_bit(start_src);
    end

    div_l_n = SIL;
    div_r_n = SIL;
    if (state_n == PLAY) begin
      div_l_n = step_div(src_n, step_n);
      div_r_n = (src_n == 2'd3) ? {div_l_n[20:0], 1'b0} : div_l_n;
    end
  end

  always_comb begin
    bus.note_div_left  = bus.mute ? SIL : div_l;
    bus.note_div_right = bus.mute ? SIL : div_r;
    bus.active_src     = src;
    bus.busy           = busy_q;
    bus.done           = done_q;
  end
endmodule

// File: tb/tb_sound_event_sequencer.sv
// Bench for sound_event_sequencer. Directed scenarios use the literal expected divisors.
// A random phase compares the design each cycle against a queue-based playback model.
module tb_sound_event_sequencer;
  localparam int CLK = 1_048_000;
  localparam int BC  = 4;
  localparam int GB  = 1;
  localparam int D_C3 = CLK / (2 * 262);
  localparam int D_C4 = CLK / (2 * 524);
  localparam int D_E4 = CLK / (2 * 660);
  localparam int D_G4 = CLK / (2 * 784);

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  sound_event_sequencer_if bus ();

  sound_event_sequencer #(
    .CLK_HZ      (CLK),
    .BEAT_CYCLES (BC),
    .GAP_BEATS   (GB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the queue holds the left divisor for every remaining cycle of the playing sequence.
  int       m_src;
  int       m_q[$];
  bit [3:1] m_pend;
  int       m_gap;
  bit       m_done;

  function automatic int hi(input bit [3:1] v);
    if (v[3]) return 3;
    if (v[2]) return 2;
    if (v[1]) return 1;
    return 0;
  endfunction

  function automatic void m_start(input int s);
    int tones[$];
    int beats[$];
    case (s)
      1:       begin tones = '{D_C4}; beats = '{2}; end
      2:       begin tones = '{D_C4, D_G4}; beats = '{1, 3}; end
      default: begin tones = '{D_G4, D_E4, D_C4, D_C3}; beats = '{2, 2, 2, 2}; end
    endcase
    m_q.delete();
    foreach (tones[i])
      for (int k = 0; k < beats[i] * BC; k++) m_q.push_back(tones[i]);
    m_src = s;
    m_gap = 0;
    m_pend[s] = 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_src = 0; m_q.delete(); m_pend = '0; m_gap = 0; m_done = 0;
    end else begin
      bit [3:1] e;
      int he;
      e  = {bus.ev_over, bus.ev_score, bus.ev_jump};
      he = hi(e);
      m_done = 0;
      m_pend |= e;
      if (m_src != 0 && he >= m_src) begin
        m_start(he);
      end else if (m_src != 0) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_done = 1;
          m_src  = 0;
          if (m_pend != 0) begin
            if (GB == 0) m_start(hi(m_pend));
            else m_gap = GB * BC;
          end
        end
      end else if (e != 0) begin
        m_start(hi(m_pend));
      end else if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) m_start(hi(m_pend));
      end
    end
  end

  task automatic test_reset();
    bus.ev_jump = 0; bus.ev_score = 0; bus.ev_over = 0; bus.mute = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.note_div_left !== 22'd1 || bus.note_div_right !== 22'd1)
      begin errors++; $display("FAIL reset_divs got %0d/%0d want 1/1", bus.note_div_left, bus.note_div_right); end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.active_src !== 2'd0)
      begin errors++; $display("FAIL reset_status got busy=%0b done=%0b src=%0d want 0/0/0", bus.busy, bus.done, bus.active_src); end
    rst_n = 1'b1;
    @(negedge clk); bus.ev_jump = 1;
    @(negedge clk); bus.ev_jump = 0;
    @(negedge clk);
    checks++;
    if (bus.note_div_left !== 22'd1000)
      begin errors++; $display("FAIL reset_preplay got %0d want 1000", bus.note_div_left); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.note_div_left !== 22'd1 || bus.note_div_right !== 22'd1)
      begin errors++; $display("FAIL reset_async_divs got %0d/%0d want 1/1", bus.note_div_left, bus.note_div_right); end
    checks++;
    if (bus.busy !== 1'b0 || bus.active_src !== 2'd0)
      begin errors++; $display("FAIL reset_async_status got busy=%0b src=%0d want 0/0", bus.busy, bus.active_src); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.note_div_left !== 22'd1)
      begin errors++; $display("FAIL reset_after got busy=%0b div=%0d want 0/1", bus.busy, bus.note_div_left); end
  endtask

  task automatic test_jump();
    @(negedge clk); bus.ev_jump = 1;
    @(negedge clk); bus.ev_jump = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.note_div_left !== 22'd1000 || bus.note_div_right !== 22'd1000)
        begin errors++; $display("FAIL jump_div c%0d got %0d/%0d want 1000/1000", i, bus.note_div_left, bus.note_div_right); end
      checks++;
      if (bus.active_src !== 2'd1 || bus.busy !== 1'b1 || bus.done !== 1'b0)
        begin errors++; $display("FAIL jump_status c%0d got src=%0d busy=%0b done=%0b want 1/1/0", i, bus.active_src, bus.busy, bus.done); end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.note_div_left !== 22'd1)
      begin errors++; $display("FAIL jump_end got done=%0b busy=%0b div=%0d want 1/0/1", bus.done, bus.busy, bus.note_div_left); end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0)
      begin errors++; $display("FAIL jump_done_width got %0b want 0", bus.done); end
  endtask

  task automatic test_score();
    int want;
    @(negedge clk); bus.ev_score = 1;
    @(negedge clk); bus.ev_score = 0;
    for (int i = 0; i < 16; i++) begin
      want = (i < 4) ? 1000 : 668;
      checks++;
      if (bus.note_div_left !== 22'(want) || bus.note_div_right !== 22'(want) || bus.done !== 1'b0)
        begin errors++; $display("FAIL score_c%0d got %0d/%0d done=%0b want %0d/%0d done=0", i, bus.note_div_left, bus.note_div_right, bus.done, want, want); end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.active_src !== 2'd0)
      begin errors++; $display("FAIL score_end got done=%0b busy=%0b src=%0d want 1/0/0", bus.done, bus.busy, bus.active_src); end
    @(negedge clk);
  endtask

  task automatic test_over();
    int lt[4] = '{668, 793, 1000, 2000};
    int rt[4] = '{1336, 1586, 2000, 4000};
    @(negedge clk); bus.ev_over = 1;
    @(negedge clk); bus.ev_over = 0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (bus.note_div_left !== 22'(lt[i/8]) || bus.note_div_right !== 22'(rt[i/8]))
        begin errors++; $display("FAIL over_c%0d got %0d/%0d want %0d/%0d", i, bus.note_div_left, bus.note_div_right, lt[i/8], rt[i/8]); end
      checks++;
      if (bus.active_src !== 2'd3 || bus.done !== 1'b0)
        begin errors++; $display("FAIL over_status_c%0d got src=%0d done=%0b want 3/0", i, bus.active_src, bus.done); end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.note_div_right !== 22'd1)
      begin errors++; $display("FAIL over_end got done=%0b busy=%0b r=%0d want 1/0/1", bus.done, bus.busy, bus.note_div_right); end
    @(negedge clk);
  endtask

  task automatic test_preempt();
    @(negedge clk); bus.ev_jump = 1;
    @(negedge clk); bus.ev_jump = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.active_src !== 2'd1)
        begin errors++; $display("FAIL preempt_jump_c%0d got src=%0d want 1", i, bus.active_src); end
      if (i == 2) bus.ev_over = 1;
      @(negedge clk);
    end
    bus.ev_over = 0;
    checks++;
    if (bus.active_src !== 2'd3 || bus.note_div_left !== 22'd668 || bus.done !== 1'b0)
      begin errors++; $display("FAIL preempt_switch got src=%0d l=%0d done=%0b want 3/668/0", bus.active_src, bus.note_div_left, bus.done); end
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.active_src !== 2'd3)
        begin errors++; $display("FAIL preempt_play_c%0d got done=%0b src=%0d want 0/3", i, bus.done, bus.active_src); end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL preempt_end got done=%0b busy=%0b want 1/0", bus.done, bus.busy); end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.active_src !== 2'd0)
      begin errors++; $display("FAIL preempt_no_resume got busy=%0b src=%0d want 0/0", bus.busy, bus.active_src); end
  endtask

  task automatic test_back_to_back();
    bus.mute = 1;
    @(negedge clk); bus.ev_score = 1; bus.ev_jump = 1;
    @(negedge clk); bus.ev_score = 0; bus.ev_jump = 0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.active_src !== 2'd2 || bus.done !== 1'b0 || bus.note_div_left !== 22'd1 || bus.note_div_right !== 22'd1)
        begin errors++; $display("FAIL b2b_score_c%0d got src=%0d done=%0b div=%0d/%0d want 2/0/1/1", i, bus.active_src, bus.done, bus.note_div_left, bus.note_div_right); end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.active_src !== 2'd0 || bus.busy !== 1'b1 || bus.done !== (i == 0))
        begin errors++; $display("FAIL b2b_gap_c%0d got src=%0d busy=%0b done=%0b want 0/1/%0b", i, bus.active_src, bus.busy, bus.done, i == 0); end
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.active_src !== 2'd1 || bus.done !== 1'b0 || bus.note_div_left !== 22'd1)
        begin errors++; $display("FAIL b2b_jump_c%0d got src=%0d done=%0b div=%0d want 1/0/1", i, bus.active_src, bus.done, bus.note_div_left); end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL b2b_end got done=%0b busy=%0b want 1/0", bus.done, bus.busy); end
    bus.mute = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int  el, er, es;
    bit  eb;
    bit  settled;
    for (int c = 0; c < 3200; c++) begin
      if (c < 3000) begin
        bus.ev_jump  = ($urandom_range(0, 11) == 0);
        bus.ev_score = ($urandom_range(0, 17) == 0);
        bus.ev_over  = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 63) == 0) bus.mute = ~bus.mute;
      end else begin
        bus.ev_jump = 0; bus.ev_score = 0; bus.ev_over = 0; bus.mute = 0;
      end
      @(negedge clk);
      es = m_src;
      eb = (m_src != 0) || (m_gap > 0);
      el = (m_src == 0 || bus.mute) ? 1 : m_q[0];
      er = (m_src == 3 && !bus.mute) ? 2 * el : el;
      checks++;
      if (bus.note_div_left !== 22'(el) || bus.note_div_right !== 22'(er))
        begin errors++; $display("FAIL rand_div c%0d got %0d/%0d want %0d/%0d", c, bus.note_div_left, bus.note_div_right, el, er); end
      checks++;
      if (bus.active_src !== 2'(es) || bus.busy !== eb || bus.done !== m_done)
        begin errors++; $display("FAIL rand_status c%0d got src=%0d busy=%0b done=%0b want %0d/%0b/%0b", c, bus.active_src, bus.busy, bus.done, es, eb, m_done); end
    end
    settled = 1'b0;
    for (int c = 0; c < 200 && !settled; c++) begin
      if (bus.busy === 1'b0 && m_src == 0 && m_gap == 0) settled = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!settled)
      begin errors++; $display("FAIL rand_settle got busy=%0b want 0 within 200 cycles", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_score();
    test_over();
    test_preempt();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
